mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-client arbiter between the instruction cache and data cache memory ports and the single shared backing-memory port.
- Cache side uses the same req / req_data / resp channel set the caches drive; memory side is one copy of that set.
- Memory returns read beats in order with no tag, so the block tracks read ownership in an in-order owner queue.
- Routes each response beat to the cache that issued the read.

Parameters:
- OUTSTANDING, 4, max in-flight read requests (owner queue depth, power of 2, ≥2)
- ADDR_W, `MEM_ADDR_BITS (28), memory beat address width
- DATA_W, `MEM_DATA_BITS (128), beat width; mask width DATA_W/8

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ic_/dc_mem_req_valid  in  1  client request valid (one each, ic_ and dc_ prefixes)
- ic_/dc_mem_req_ready  out  1  client request accepted
- ic_/dc_mem_req_addr  in  ADDR_W  beat address
- ic_/dc_mem_req_rw  in  1  1 = write
- ic_/dc_mem_req_data_valid  in  1  write data valid
- ic_/dc_mem_req_data_ready  out  1  write data accepted
- ic_/dc_mem_req_data_bits  in  DATA_W  write data
- ic_/dc_mem_req_data_mask  in  DATA_W/8  byte mask
- ic_/dc_mem_resp_valid  out  1  read beat for this client
- ic_/dc_mem_resp_data  out  DATA_W  read beat data (shared fanout of mem_resp_data)
- mem_req_valid, mem_req_addr, mem_req_rw, mem_req_data_valid, mem_req_data_bits, mem_req_data_mask  out  matching widths  to memory
- mem_req_ready, mem_req_data_ready  in  1  from memory
- mem_resp_valid  in  1; mem_resp_data  in  DATA_W  read beat from memory
- resp_orphan  out  1  sticky: response arrived with empty owner queue

Behaviour:
- Reset:
  - Owner queue empty, no pending write, round-robin pointer favours dc, resp_orphan=0.
  - All out valids and readies are 0 while reset is high.
- Grant:
  - Combinational and evaluated every cycle; blocked if wdata_pending=1, or if the queue is full at cycle start.
  - If unblocked and both clients are valid, the round-robin winner is chosen.
  - mem_req_* mirrors the winner. Winner's req_ready = mem_req_ready; loser's req_ready = 0.
  - Pointer moves to the other client only on a handshake where both were requesting.
- Read handshake (rw=0): push winner ID to owner queue at posedge.
  - No push when the queue was full at cycle start, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle otherwise allowed; count unchanged.
- Write handshake (rw=1): write data channel is routed to the winner in the same cycle.
  - If data also handshakes in that cycle, the write is done.
  - Otherwise set wdata_pending=1 and wdata_owner=winner. mem_req_valid=0 and both req_ready=0 until the owner's data handshake, then clear pending.
  - Data channel is never routed to a client without an accepted write request; its data_ready=0.
- Response: on mem_resp_valid, assert resp_valid of the queue-head owner in the same cycle (combinational), and pop.
  - Empty queue: drop the beat, set resp_orphan.
- Latency: request path and response path are both 0 cycles combinational; no registering of data.
- Reset mid-operation: pending write and queue contents discarded; memory-side in-flight state is the memory model's concern.

Decomposition:
- Shared package/header: client ID constants CLIENT_IC=0, CLIENT_DC=1; ADDR_W/DATA_W from const.vh.
- One sub-module: owner_fifo
  - Parameterised depth, 1-bit entries.
  - Ports push/pop/full/empty/head.
  - Synchronous reset.
  - Read/write pointers one bit wider than the index, for full/empty detection.

Test Plan:
- Single dc read at addr 0x0000010, mem_req_ready=1; one cycle later mem_resp_valid with data 0xAA..AA -> dc_mem_resp_valid=1 with 0xAA..AA, ic_mem_resp_valid=0, queue empty after.
- ic and dc both valid reads every cycle, mem_req_ready=1, responses held off -> grants alternate dc, ic, dc, ic; 5th request blocked (ready=0) with OUTSTANDING=4. Then 4 beats -> routed dc, ic, dc, ic.
- dc write with data_valid delayed 3 cycles, ic read requesting throughout -> ic_mem_req_ready=0 until dc data handshake. ic read is granted the cycle after the data handshake.
- Write where mem_req_data_ready=1 in the request cycle -> no pending state, other client grantable next cycle.
- Queue full, pop and read request in same cycle -> no push that cycle; push next cycle; count ends at 4.
- mem_resp_valid with empty queue -> no client resp_valid, resp_orphan=1 until reset. Reset asserted with 2 reads outstanding -> queue empty, resp_orphan=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the instruction/data cache memory arbiter:
//   memory beat widths, client identifiers, the write-data state type and a
//   small helper for the round-robin pointer.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    // Backing-memory beat geometry.
    localparam int MEM_ADDR_BITS = 28;
    localparam int MEM_DATA_BITS = 128;

    // Client identifiers; also the value stored in the owner queue.
    localparam logic CLIENT_IC = 1'b0;
    localparam logic CLIENT_DC = 1'b1;

    // Write-data channel state: idle, or waiting for the data beat of an
    // already accepted write request.
    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_DATA = 1'b1
    } wr_state_t;

    // The client that is not `id`.
    function automatic logic other_client(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   One memory port: request channel (req_*), write-data channel
//   (req_data_*) and read-response channel (resp_*).
//
//   Handshake rule for both request channels: a transfer happens in a cycle
//   where valid and ready are both 1. The response channel has no ready; a
//   beat is consumed in the cycle resp_valid is 1.
//
//   Modports:
//     master - the side that issues requests (a cache, or the arbiter toward
//              memory)
//     slave  - the side that accepts requests (the memory, or the arbiter
//              toward a cache)
// -----------------------------------------------------------------------------
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_BITS,
    parameter int DATA_W = MEM_DATA_BITS
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic                  req_rw;
    logic                  req_data_valid;
    logic                  req_data_ready;
    logic [DATA_W-1:0]     req_data_bits;
    logic [DATA_W/8-1:0]   req_data_mask;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_data;

    modport master (
        output req_valid, req_addr, req_rw,
        output req_data_valid, req_data_bits, req_data_mask,
        input  req_ready, req_data_ready,
        input  resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr, req_rw,
        input  req_data_valid, req_data_bits, req_data_mask,
        output req_ready, req_data_ready,
        output resp_valid, resp_data
    );
endinterface

// File: rtl/mem_arbiter_owner_fifo.sv
// -----------------------------------------------------------------------------
// mem_arbiter_owner_fifo
//   In-order queue of 1-bit client IDs, one entry per outstanding read.
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
//
//   Ports:
//     clk, reset  - clock, synchronous active-high reset (empties the queue)
//     i_push      - enqueue i_push_id (ignored while full)
//     i_push_id   - client ID to enqueue
//     i_pop       - dequeue head (ignored while empty)
//     o_full      - DEPTH entries held
//     o_empty     - no entries held
//     o_head      - ID at the head of the queue
//     o_count     - number of entries held
// -----------------------------------------------------------------------------
module mem_arbiter_owner_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_push_id,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_head,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [IDX_W:0]   r_wptr;
    logic [IDX_W:0]   r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[IDX_W] != r_rptr[IDX_W]) &&
                       (r_wptr[IDX_W-1:0] == r_rptr[IDX_W-1:0]);
    assign o_head    = r_mem[r_rptr[IDX_W-1:0]];
    assign o_count   = r_wptr - r_rptr;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_mem  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr[IDX_W-1:0]] <= i_push_id;
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one backing-memory port between the instruction cache and the data
//   cache. Requests are granted combinationally with round-robin priority;
//   read ownership is recorded in an in-order owner queue so untagged
//   response beats return to the cache that issued the read. A write whose
//   data beat lags its request holds off all further grants until that beat
//   is transferred.
//
//   Ports:
//     clk, reset       - clock, synchronous active-high reset
//     ic_mem, dc_mem   - cache-facing ports (slave side)
//     mem              - memory-facing port (master side)
//     resp_orphan      - sticky: a response beat arrived with no owner
//     o_dbg_wr_state   - write-data state (WR_IDLE / WR_DATA)
//     o_dbg_q_count    - number of reads in flight
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 4,
    parameter int ADDR_W      = MEM_ADDR_BITS,
    parameter int DATA_W      = MEM_DATA_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    mem_arbiter_if.slave                 ic_mem,
    mem_arbiter_if.slave                 dc_mem,
    mem_arbiter_if.master                mem,
    output logic                         resp_orphan,
    output wr_state_t                    o_dbg_wr_state,
    output logic [$clog2(OUTSTANDING):0] o_dbg_q_count
);
    // Registers
    wr_state_t r_wr_state;
    logic      r_wdata_owner;
    logic      r_rr_prio;      // client favoured when both request
    logic      r_orphan;

    // Next-state for the write-data FSM
    wr_state_t w_next_wr_state;
    logic      w_next_wdata_owner;

    // Grant path
    logic              w_both;
    logic              w_any;
    logic              w_winner;
    logic              w_blocked;
    logic              w_grant_valid;
    logic              w_req_fire;
    logic [ADDR_W-1:0] w_win_addr;
    logic              w_win_rw;

    // Write-data path
    logic                w_data_active;
    logic                w_data_owner;
    logic                w_data_fire;
    logic                w_owner_dvalid;
    logic [DATA_W-1:0]   w_owner_dbits;
    logic [DATA_W/8-1:0] w_owner_dmask;

    // Owner queue
    logic w_q_full;
    logic w_q_empty;
    logic w_q_head;
    logic w_q_push;
    logic w_q_pop;
    logic w_resp_hit;

    // ---------------------------------------------------------------- grant
    assign w_both = ic_mem.req_valid && dc_mem.req_valid;
    assign w_any  = ic_mem.req_valid || dc_mem.req_valid;

    always_comb begin
        w_winner = CLIENT_IC;
        if (w_both) begin
            w_winner = r_rr_prio;
        end else if (dc_mem.req_valid) begin
            w_winner = CLIENT_DC;
        end
    end

    // A full queue blocks writes too: grants are decided before the request
    // type is looked at, keeping the grant a pure function of state + valids.
    assign w_blocked     = reset || (r_wr_state == WR_DATA) || w_q_full;
    assign w_grant_valid = w_any && !w_blocked;
    assign w_req_fire    = w_grant_valid && mem.req_ready;

    assign w_win_addr = (w_winner == CLIENT_DC) ? dc_mem.req_addr : ic_mem.req_addr;
    assign w_win_rw   = (w_winner == CLIENT_DC) ? dc_mem.req_rw   : ic_mem.req_rw;

    assign mem.req_valid = w_grant_valid;
    assign mem.req_addr  = w_win_addr;
    assign mem.req_rw    = w_win_rw;

    assign ic_mem.req_ready = w_grant_valid && mem.req_ready && (w_winner == CLIENT_IC);
    assign dc_mem.req_ready = w_grant_valid && mem.req_ready && (w_winner == CLIENT_DC);

    // ----------------------------------------------------------- write data
    // The data channel opens in the cycle a write request is accepted and
    // stays open to the same client until its beat transfers.
    assign w_data_active = !reset &&
                           ((r_wr_state == WR_DATA) || (w_req_fire && w_win_rw));
    assign w_data_owner  = (r_wr_state == WR_DATA) ? r_wdata_owner : w_winner;

    assign w_owner_dvalid = (w_data_owner == CLIENT_DC) ? dc_mem.req_data_valid
                                                        : ic_mem.req_data_valid;
    assign w_owner_dbits  = (w_data_owner == CLIENT_DC) ? dc_mem.req_data_bits
                                                        : ic_mem.req_data_bits;
    assign w_owner_dmask  = (w_data_owner == CLIENT_DC) ? dc_mem.req_data_mask
                                                        : ic_mem.req_data_mask;

    assign mem.req_data_valid = w_data_active && w_owner_dvalid;
    assign mem.req_data_bits  = w_owner_dbits;
    assign mem.req_data_mask  = w_owner_dmask;
    assign w_data_fire        = mem.req_data_valid && mem.req_data_ready;

    assign ic_mem.req_data_ready = w_data_active && mem.req_data_ready &&
                                   (w_data_owner == CLIENT_IC);
    assign dc_mem.req_data_ready = w_data_active && mem.req_data_ready &&
                                   (w_data_owner == CLIENT_DC);

    always_comb begin
        w_next_wr_state    = r_wr_state;
        w_next_wdata_owner = r_wdata_owner;
        case (r_wr_state)
            WR_IDLE: begin
                if (w_req_fire && w_win_rw && !w_data_fire) begin
                    w_next_wr_state    = WR_DATA;
                    w_next_wdata_owner = w_winner;
                end
            end
            WR_DATA: begin
                if (w_data_fire) begin
                    w_next_wr_state = WR_IDLE;
                end
            end
            default: w_next_wr_state = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_state    <= WR_IDLE;
            r_wdata_owner <= CLIENT_IC;
        end else begin
            r_wr_state    <= w_next_wr_state;
            r_wdata_owner <= w_next_wdata_owner;
        end
    end

    // Round-robin: only a contested handshake hands priority to the loser.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_prio <= CLIENT_DC;
        end else if (w_req_fire && w_both) begin
            r_rr_prio <= other_client(w_winner);
        end
    end

    // ------------------------------------------------------------- response
    assign w_q_push   = w_req_fire && !w_win_rw;
    assign w_resp_hit = !reset && mem.resp_valid && !w_q_empty;
    assign w_q_pop    = w_resp_hit;

    assign ic_mem.resp_valid = w_resp_hit && (w_q_head == CLIENT_IC);
    assign dc_mem.resp_valid = w_resp_hit && (w_q_head == CLIENT_DC);
    assign ic_mem.resp_data  = mem.resp_data;
    assign dc_mem.resp_data  = mem.resp_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_orphan <= 1'b0;
        end else if (mem.resp_valid && w_q_empty) begin
            r_orphan <= 1'b1;
        end
    end

    mem_arbiter_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_q_push),
        .i_push_id (w_winner),
        .i_pop     (w_q_pop),
        .o_full    (w_q_full),
        .o_empty   (w_q_empty),
        .o_head    (w_q_head),
        .o_count   (o_dbg_q_count)
    );

    assign resp_orphan    = r_orphan;
    assign o_dbg_wr_state = r_wr_state;
endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter: reset, single read, contested reads up to
//   queue full, delayed and immediate write data, full-queue pop/push timing,
//   orphan responses and reset with reads outstanding.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 28;
    localparam int DW = 128;

    logic      clk = 1'b0;
    logic      reset;
    logic      resp_orphan;
    wr_state_t dbg_wr_state;
    logic [2:0] dbg_q_count;

    int errors = 0;
    int checks = 0;

    logic [127:0] beat;
    logic         exp_dc;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ic_if ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dc_if ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m_if ();

    mem_arbiter #(
        .OUTSTANDING (4),
        .ADDR_W      (AW),
        .DATA_W      (DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ic_mem         (ic_if),
        .dc_mem         (dc_if),
        .mem            (m_if),
        .resp_orphan    (resp_orphan),
        .o_dbg_wr_state (dbg_wr_state),
        .o_dbg_q_count  (dbg_q_count)
    );

    // ------------------------------------------------------- clock / reset
    always #5 clk = ~clk;

    // --------------------------------------------------------- driver tasks
    // Inputs change 1 time unit after the rising edge; checks run 1 unit
    // later, well clear of either clock edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        ic_if.req_valid      = 1'b0;
        ic_if.req_addr       = '0;
        ic_if.req_rw         = 1'b0;
        ic_if.req_data_valid = 1'b0;
        ic_if.req_data_bits  = '0;
        ic_if.req_data_mask  = '0;
        dc_if.req_valid      = 1'b0;
        dc_if.req_addr       = '0;
        dc_if.req_rw         = 1'b0;
        dc_if.req_data_valid = 1'b0;
        dc_if.req_data_bits  = '0;
        dc_if.req_data_mask  = '0;
        m_if.req_ready       = 1'b0;
        m_if.req_data_ready  = 1'b0;
        m_if.resp_valid      = 1'b0;
        m_if.resp_data       = '0;
    endtask

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();

        // Reset: outputs quiet even with traffic present.
        ic_if.req_valid = 1'b1;
        m_if.req_ready  = 1'b1;
        m_if.req_data_ready = 1'b1;
        m_if.resp_valid = 1'b1;
        settle();
        check("rst_mem_req_valid", m_if.req_valid, 0);
        check("rst_ic_req_ready", ic_if.req_ready, 0);
        check("rst_ic_data_ready", ic_if.req_data_ready, 0);
        check("rst_ic_resp_valid", ic_if.resp_valid, 0);
        check("rst_dc_resp_valid", dc_if.resp_valid, 0);
        tick();
        check("rst_q_count", dbg_q_count, 0);
        check("rst_orphan", resp_orphan, 0);
        check("rst_wr_state", dbg_wr_state, WR_IDLE);
        clear_inputs();
        reset = 1'b0;
        tick();

        // Single dc read, response one cycle later.
        m_if.req_ready  = 1'b1;
        dc_if.req_valid = 1'b1;
        dc_if.req_addr  = 28'h0000010;
        settle();
        check("t1_mem_req_valid", m_if.req_valid, 1);
        check("t1_mem_req_addr", m_if.req_addr, 28'h0000010);
        check("t1_mem_req_rw", m_if.req_rw, 0);
        check("t1_dc_req_ready", dc_if.req_ready, 1);
        check("t1_ic_req_ready", ic_if.req_ready, 0);
        tick();
        dc_if.req_valid = 1'b0;
        check("t1_q_count_1", dbg_q_count, 1);
        m_if.resp_valid = 1'b1;
        m_if.resp_data  = {16{8'hAA}};
        settle();
        check("t1_dc_resp_valid", dc_if.resp_valid, 1);
        check("t1_dc_resp_data", dc_if.resp_data, {16{8'hAA}});
        check("t1_ic_resp_valid", ic_if.resp_valid, 0);
        tick();
        m_if.resp_valid = 1'b0;
        check("t1_q_count_0", dbg_q_count, 0);
        check("t1_orphan", resp_orphan, 0);

        // Both clients reading every cycle: dc, ic, dc, ic, then blocked.
        ic_if.req_valid = 1'b1;
        ic_if.req_addr  = 28'h0000100;
        dc_if.req_valid = 1'b1;
        dc_if.req_addr  = 28'h0000200;
        for (int i = 0; i < 4; i++) begin
            exp_dc = (i % 2 == 0);
            settle();
            check($sformatf("t2_dc_ready_%0d", i), dc_if.req_ready, exp_dc);
            check($sformatf("t2_ic_ready_%0d", i), ic_if.req_ready, !exp_dc);
            check($sformatf("t2_addr_%0d", i), m_if.req_addr,
                  exp_dc ? 28'h0000200 : 28'h0000100);
            tick();
        end
        settle();
        check("t2_q_full_count", dbg_q_count, 4);
        check("t2_blocked_valid", m_if.req_valid, 0);
        check("t2_blocked_ic_ready", ic_if.req_ready, 0);
        check("t2_blocked_dc_ready", dc_if.req_ready, 0);
        tick();
        ic_if.req_valid = 1'b0;
        dc_if.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_dc = (i % 2 == 0);
            beat = 128'hB000 + 128'(i);
            m_if.resp_valid = 1'b1;
            m_if.resp_data  = beat;
            settle();
            check($sformatf("t2_dc_resp_%0d", i), dc_if.resp_valid, exp_dc);
            check($sformatf("t2_ic_resp_%0d", i), ic_if.resp_valid, !exp_dc);
            check($sformatf("t2_resp_data_%0d", i),
                  exp_dc ? dc_if.resp_data : ic_if.resp_data, beat);
            tick();
        end
        m_if.resp_valid = 1'b0;
        check("t2_q_drained", dbg_q_count, 0);

        // dc write with data 3 cycles late; ic read waits. Priority is dc.
        m_if.req_data_ready = 1'b1;
        dc_if.req_valid = 1'b1;
        dc_if.req_rw    = 1'b1;
        dc_if.req_addr  = 28'h0000300;
        ic_if.req_valid = 1'b1;
        ic_if.req_rw    = 1'b0;
        ic_if.req_addr  = 28'h0000400;
        settle();
        check("t3_dc_req_ready", dc_if.req_ready, 1);
        check("t3_ic_req_ready_c0", ic_if.req_ready, 0);
        check("t3_mem_rw", m_if.req_rw, 1);
        check("t3_mem_data_valid_c0", m_if.req_data_valid, 0);
        tick();
        dc_if.req_valid = 1'b0;
        dc_if.req_rw    = 1'b0;
        for (int i = 1; i < 3; i++) begin
            settle();
            check($sformatf("t3_pending_state_%0d", i), dbg_wr_state, WR_DATA);
            check($sformatf("t3_ic_blocked_%0d", i), ic_if.req_ready, 0);
            check($sformatf("t3_mem_valid_%0d", i), m_if.req_valid, 0);
            check($sformatf("t3_dc_dready_%0d", i), dc_if.req_data_ready, 1);
            check($sformatf("t3_ic_dready_%0d", i), ic_if.req_data_ready, 0);
            tick();
        end
        dc_if.req_data_valid = 1'b1;
        dc_if.req_data_bits  = {16{8'h55}};
        dc_if.req_data_mask  = 16'hF0F0;
        settle();
        check("t3_mem_data_valid", m_if.req_data_valid, 1);
        check("t3_mem_data_bits", m_if.req_data_bits, {16{8'h55}});
        check("t3_mem_data_mask", m_if.req_data_mask, 16'hF0F0);
        check("t3_ic_blocked_c3", ic_if.req_ready, 0);
        tick();
        dc_if.req_data_valid = 1'b0;
        settle();
        check("t3_state_idle", dbg_wr_state, WR_IDLE);
        check("t3_ic_granted", ic_if.req_ready, 1);
        check("t3_ic_addr", m_if.req_addr, 28'h0000400);
        check("t3_mem_data_valid_after", m_if.req_data_valid, 0);
        tick();
        ic_if.req_valid = 1'b0;
        check("t3_q_count", dbg_q_count, 1);
        m_if.resp_valid = 1'b1;
        m_if.resp_data  = 128'h1234;
        settle();
        check("t3_ic_resp", ic_if.resp_valid, 1);
        check("t3_dc_resp", dc_if.resp_valid, 0);
        tick();
        m_if.resp_valid = 1'b0;

        // ic write with data ready immediately; dc read next cycle.
        // Priority is ic after the contested write grant above.
        ic_if.req_valid      = 1'b1;
        ic_if.req_rw         = 1'b1;
        ic_if.req_addr       = 28'h0000500;
        ic_if.req_data_valid = 1'b1;
        ic_if.req_data_bits  = 128'hC0FFEE;
        ic_if.req_data_mask  = 16'hFFFF;
        dc_if.req_valid      = 1'b1;
        dc_if.req_addr       = 28'h0000600;
        settle();
        check("t4_ic_req_ready", ic_if.req_ready, 1);
        check("t4_dc_req_ready", dc_if.req_ready, 0);
        check("t4_ic_data_ready", ic_if.req_data_ready, 1);
        check("t4_mem_data_valid", m_if.req_data_valid, 1);
        check("t4_mem_data_bits", m_if.req_data_bits, 128'hC0FFEE);
        tick();
        ic_if.req_valid      = 1'b0;
        ic_if.req_rw         = 1'b0;
        ic_if.req_data_valid = 1'b0;
        settle();
        check("t4_state_idle", dbg_wr_state, WR_IDLE);
        check("t4_dc_granted", dc_if.req_ready, 1);
        check("t4_dc_addr", m_if.req_addr, 28'h0000600);
        tick();
        dc_if.req_valid = 1'b0;
        m_if.resp_valid = 1'b1;
        settle();
        check("t4_dc_resp", dc_if.resp_valid, 1);
        tick();
        m_if.resp_valid = 1'b0;
        check("t4_q_empty", dbg_q_count, 0);

        // Full queue: pop and request together -> no push until next cycle.
        dc_if.req_valid = 1'b1;
        dc_if.req_addr  = 28'h0000700;
        tick();
        tick();
        tick();
        tick();
        check("t5_q_full", dbg_q_count, 4);
        m_if.resp_valid = 1'b1;
        settle();
        check("t5_full_dc_ready", dc_if.req_ready, 0);
        check("t5_full_mem_valid", m_if.req_valid, 0);
        check("t5_pop_dc_resp", dc_if.resp_valid, 1);
        tick();
        m_if.resp_valid = 1'b0;
        check("t5_count_3", dbg_q_count, 3);
        settle();
        check("t5_dc_ready_next", dc_if.req_ready, 1);
        tick();
        dc_if.req_valid = 1'b0;
        check("t5_count_4", dbg_q_count, 4);
        m_if.resp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("t5_drain_dc_%0d", i), dc_if.resp_valid, 1);
            tick();
        end
        m_if.resp_valid = 1'b0;
        check("t5_drained", dbg_q_count, 0);

        // Orphan beat, then reset with two reads outstanding.
        m_if.resp_valid = 1'b1;
        settle();
        check("t6_orphan_ic_resp", ic_if.resp_valid, 0);
        check("t6_orphan_dc_resp", dc_if.resp_valid, 0);
        tick();
        m_if.resp_valid = 1'b0;
        check("t6_orphan_set", resp_orphan, 1);
        dc_if.req_valid = 1'b1;
        tick();
        tick();
        dc_if.req_valid = 1'b0;
        check("t6_q_count_2", dbg_q_count, 2);
        check("t6_orphan_sticky", resp_orphan, 1);
        reset = 1'b1;
        dc_if.req_valid = 1'b1;
        settle();
        check("t6_rst_dc_ready", dc_if.req_ready, 0);
        tick();
        reset = 1'b0;
        dc_if.req_valid = 1'b0;
        check("t6_rst_q_empty", dbg_q_count, 0);
        check("t6_rst_orphan", resp_orphan, 0);
        m_if.resp_valid = 1'b1;
        settle();
        check("t6_after_rst_no_resp", dc_if.resp_valid, 0);
        tick();
        m_if.resp_valid = 1'b0;

        // ------------------------------------------------------------ report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
